voxel_world_generator: RTL and testbench

// - Procedural voxel-world builder: on a start pulse, writes every cell of a GRID_SIZE^3

---
 rtl/voxel_world_generator.sv | 98 +++++++++
 tb/tb_voxel_world_generator.sv | 139 +++++++++++++
 2 files changed

// File: rtl/voxel_world_generator.sv
// Procedural voxel-world builder: streams one terrain word per cell of a GRID_SIZE^3 volume.
// Optional marker pillar through the volume centre when VOXEL_WORLD_PILLAR_EN is defined.
module voxel_world_generator #(
  parameter  int unsigned GRID_SIZE = 64,
  localparam int unsigned AXIS_BITS = $clog2(GRID_SIZE),
  localparam int unsigned AW        = 3 * AXIS_BITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          write_en,
  output logic [AW-1:0] write_addr,
  output logic [63:0]   write_data
);

  localparam int unsigned HW        = AXIS_BITS + 1;
  localparam int unsigned SHIFT     = AXIS_BITS - 3;
  localparam int unsigned N_CELLS   = GRID_SIZE * GRID_SIZE * GRID_SIZE;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_CELLS - 1);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic            busy_nxt, done_nxt, en_nxt;
  logic [AW-1:0]   addr_nxt;
  logic [63:0]     data_nxt;

  // Terrain (and optional pillar) word for one cell address {z,y,x}.
  function automatic logic [63:0] voxel_word(input logic [AW-1:0] addr);
    logic [AXIS_BITS-1:0] x, y, z;
    logic [HW-1:0]        h, yy;
    logic [7:0]           mat, light;
    x  = addr[AXIS_BITS-1:0];
    y  = addr[2*AXIS_BITS-1:AXIS_BITS];
    z  = addr[AW-1:2*AXIS_BITS];
    yy = HW'(y);
    h  = HW'(GRID_SIZE / 4) + HW'(x >> SHIFT) + HW'(z >> SHIFT);
    if (yy == '0)                 mat = 8'd1;
    else if (yy >= h)             mat = 8'd0;
    else if (yy == h - HW'(1))    mat = 8'd4;
    else if (yy >= h - HW'(4))    mat = 8'd3;
    else                          mat = 8'd2;
`ifdef VOXEL_WORLD_PILLAR_EN
    if (x == AXIS_BITS'(GRID_SIZE / 2) && z == AXIS_BITS'(GRID_SIZE / 2) &&
        32'(y) < (3 * GRID_SIZE) / 4)
      mat = 8'd5;
`endif
    light = 8'(32'(y) << 2);
    return (mat == 8'd0) ? 64'd0 : {40'd0, light, 8'hFF, mat};
  endfunction

  // State and registered outputs; the address register doubles as the cell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= 64'd0;
    end else begin
      state      <= state_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      write_en   <= en_nxt;
      write_addr <= addr_nxt;
      write_data <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (write_addr == LAST_ADDR) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next output values; data is computed from the address it will accompany.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    en_nxt   = 1'b0;
    addr_nxt = '0;
    data_nxt = 64'd0;
    if (state == RUN && write_addr == LAST_ADDR) done_nxt = 1'b1;
    if (state_nxt == RUN) begin
      busy_nxt = 1'b1;
      en_nxt   = 1'b1;
      addr_nxt = (state == RUN) ? write_addr + AW'(1) : '0;
      data_nxt = voxel_word(addr_nxt);
    end
  end

endmodule

// File: tb/tb_voxel_world_generator.sv
// Directed bench: a 64-grid instance for early-cell terrain words and mid-build reset,
// and a 16-grid instance for full-build count, restart rules and boundary cells.
module tb_voxel_world_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start64 = 1'b0;
  logic        start16 = 1'b0;

  logic        busy64, done64, en64;
  logic [17:0] addr64;
  logic [63:0] data64;
  logic        busy16, done16, en16;
  logic [11:0] addr16;
  logic [63:0] data16;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  voxel_world_generator dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .busy(busy64), .done(done64),
    .write_en(en64), .write_addr(addr64), .write_data(data64)
  );

  voxel_world_generator #(.GRID_SIZE(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .busy(busy16), .done(done16),
    .write_en(en16), .write_addr(addr16), .write_data(data16)
  );

`ifdef VOXEL_WORLD_PILLAR_EN
  localparam logic [63:0] PILLAR_Y11 = 64'h2CFF05;
`else
  localparam logic [63:0] PILLAR_Y11 = 64'h2CFF04;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] st64();
    return 64'({busy64, done64, en64, addr64});
  endfunction

  function automatic logic [63:0] st16();
    return 64'({busy16, done16, en16, addr16});
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_status64", st64(), 64'd0);
    check("reset_data64",   data64, 64'd0);
    check("reset_status16", st16(), 64'd0);
    check("reset_data16",   data16, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_status16", st16(), 64'd0);
    start64 = 1'b1;
    start16 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    start16 = 1'b0;

    // Full 16-grid build; 64-grid build runs alongside.
    for (int k = 0; k < 4096; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 100) start16 = 1'b1;
      if (k == 101) start16 = 1'b0;
      check("run_status16", st16(), 64'({3'b101, 12'(k)}));
      check("run_status64", st64(), 64'({3'b101, 18'(k)}));
      if (k == 0)    check("g16_bedrock",    data16, 64'h0000_0000_0000_FF01);
      if (k == 16)   check("g16_dirt_y1",    data16, 64'h04FF03);
      if (k == 48)   check("g16_grass_y3",   data16, 64'h0CFF04);
      if (k == 64)   check("g16_air_y4",     data16, 64'h0);
      if (k == 2232) check("g16_pillar_y11", data16, PILLAR_Y11);
      if (k == 2248) check("g16_air_y12",    data16, 64'h0);
      if (k == 4063) check("g16_stone_y13",  data16, 64'h34FF02);
      if (k == 4095) check("g16_dirt_last",  data16, 64'h3CFF03);
      if (k == 0)    check("g64_bedrock",    data64, 64'h0000_0000_0000_FF01);
      if (k == 896)  check("g64_dirt_y14",   data64, 64'h38FF03);
      if (k == 960)  check("g64_grass_y15",  data64, 64'h3CFF04);
      if (k == 1024) check("g64_air_y16",    data64, 64'h0);
    end

    // Done cycle, with a start accepted during it.
    @(negedge clk);
    check("done_status16", st16(), 64'({3'b010, 12'd0}));
    check("done_data16",   data16, 64'd0);
    check("still_run64",   st64(), 64'({3'b101, 18'd4096}));
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    check("rerun_status16", st16(), 64'({3'b101, 12'd0}));
    check("rerun_data16",   data16, 64'h0000_0000_0000_FF01);
    for (int j = 1; j <= 903; j++) begin
      @(negedge clk);
      check("rerun_addr16", st16(), 64'({3'b101, 12'(j)}));
    end
    check("cycle5000_64", st64(), 64'({3'b101, 18'd5000}));

    // Asynchronous abort mid-build.
    #1 rst_n = 1'b0;
    #1;
    check("abort_status64", st64(), 64'd0);
    check("abort_data64",   data64, 64'd0);
    check("abort_status16", st16(), 64'd0);
    check("abort_data16",   data16, 64'd0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("held_status64", st64(), 64'd0);
      check("held_status16", st16(), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle64", st64(), 64'd0);
    start64 = 1'b1;
    start16 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    start16 = 1'b0;
    check("restart_status64", st64(), 64'({3'b101, 18'd0}));
    check("restart_data64",   data64, 64'h0000_0000_0000_FF01);
    check("restart_status16", st16(), 64'({3'b101, 12'd0}));
    @(negedge clk);
    check("restart_next64", st64(), 64'({3'b101, 18'd1}));
    check("restart_next16", st16(), 64'({3'b101, 12'd1}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
